// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-8 demultiplexer slice.
package demux_pkg;

  localparam int NUM_OUT = 8;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_OUT-1:0] onehot_t;

endpackage : demux_pkg

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
// The enable gates the whole bus, so y is all-zero whenever en is low,
// even if sel carries X/Z.
module decoder_3to8
  import demux_pkg::*;
(
  input  sel_t    sel,
  input  logic    en,
  output onehot_t y
);

  // Raise only the bit addressed by sel, and only while enabled.
  always_comb begin
    y = '0;
    if (en) begin
      y[sel] = 1'b1;
    end
  end

endmodule : decoder_3to8

// File: rtl/demux_1to8.sv
// 1-to-8 demultiplexer: steers e onto the output chosen by {a,b,c}.
// REGISTER_OUT=1 adds one flop stage (one-cycle latency, outputs cleared
// asynchronously by rst_n); REGISTER_OUT=0 is a pure combinational path.
module demux_1to8
  import demux_pkg::*;
#(
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic e,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7
);

  sel_t    sel;
  onehot_t dec;
  onehot_t y;

  assign sel = {a, b, c};

  decoder_3to8 u_dec (
    .sel (sel),
    .en  (e),
    .y   (dec)
  );

  generate
    if (REGISTER_OUT) begin : g_reg
      onehot_t d_p0;

      // Stage p0: capture the decode each edge; reset clears all outputs at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_p0 <= '0;
        end else begin
          d_p0 <= dec;
        end
      end

      assign y = d_p0;
    end else begin : g_comb
      // clk and rst_n play no part in the combinational variant.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};

      assign y = dec;
    end
  endgenerate

  assign {d7, d6, d5, d4, d3, d2, d1, d0} = y;

endmodule : demux_1to8

// File: tb/tb_demux_1to8.sv
// Bench for demux_1to8: registered and combinational instances side by side,
// checked against a shift-based one-hot reference model.
module tb_demux_1to8;

  logic clk;
  logic rst_n;
  logic clk_c;
  logic rst_n_c;
  logic a, b, c, e;

  logic r0, r1, r2, r3, r4, r5, r6, r7;
  logic c0, c1, c2, c3, c4, c5, c6, c7;

  logic [7:0] dr;
  logic [7:0] dc;
  logic [7:0] exp_q;

  int vectors;
  int errs;

  assign dr = {r7, r6, r5, r4, r3, r2, r1, r0};
  assign dc = {c7, c6, c5, c4, c3, c2, c1, c0};

  demux_1to8 #(.REGISTER_OUT(1'b1)) u_reg (
    .clk (clk), .rst_n (rst_n),
    .a (a), .b (b), .c (c), .e (e),
    .d0 (r0), .d1 (r1), .d2 (r2), .d3 (r3),
    .d4 (r4), .d5 (r5), .d6 (r6), .d7 (r7)
  );

  demux_1to8 #(.REGISTER_OUT(1'b0)) u_comb (
    .clk (clk_c), .rst_n (rst_n_c),
    .a (a), .b (b), .c (c), .e (e),
    .d0 (c0), .d1 (c1), .d2 (c2), .d3 (c3),
    .d4 (c4), .d5 (c5), .d6 (c6), .d7 (c7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: enable shifted into the selected bit position.
  function automatic logic [7:0] model(input int sel, input logic en);
    return en ? (8'd1 << sel) : 8'd0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic check_onehot(input string tag, input logic [7:0] obs);
    check(tag, ($countones(obs) > 1) ? 8'hFF : 8'h00, 8'h00);
  endtask

  // Called at a negedge: drive inputs, confirm the registered outputs hold
  // until the edge while the combinational copy follows at once, then check
  // the registered result one negedge later.
  task automatic apply(input string tag, input int sel, input logic en);
    logic [7:0] nxt;
    {a, b, c} = sel[2:0];
    e = en;
    nxt = model(sel, en);
    #1;
    check({tag, "_hold"}, dr, exp_q);
    check({tag, "_comb"}, dc, nxt);
    @(negedge clk);
    exp_q = nxt;
    check({tag, "_reg"}, dr, exp_q);
    check_onehot({tag, "_1hot"}, dr);
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    clk_c   = 1'b0;
    rst_n_c = 1'b1;
    exp_q   = 8'h00;

    // Reset with a decode of 7 pending: outputs must be 0 before any edge.
    rst_n = 1'b0;
    {a, b, c} = 3'b111;
    e = 1'b1;
    #2;
    check("rst_async", dr, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", dr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_noedge", dr, 8'h00);
    @(negedge clk);
    exp_q = model(7, 1'b1);
    check("rst_first_edge", dr, exp_q);

    // Enabled sweep, ending on 000 so the next step exercises 000 -> 111.
    for (int s = 1; s < 8; s++) apply("sweep_en", s, 1'b1);
    apply("sweep_en0", 0, 1'b1);
    apply("lat_0to7", 7, 1'b1);

    // Disabled sweep.
    for (int s = 0; s < 8; s++) apply("sweep_dis", s, 1'b0);

    // Mid-run reset on d4.
    apply("pre_rst", 4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_clear", dr, 8'h00);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_release", dr, 8'h00);
    @(negedge clk);
    check("midrst_reload", dr, exp_q);

    // Randomized traffic; rst_n of the combinational copy toggles to show it is ignored.
    for (int i = 0; i < 120; i++) begin
      rst_n_c = 1'($urandom_range(0, 1));
      apply("rand", int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // Combinational variant on its own, its clock never toggling.
    rst_n_c = 1'b0;
    {a, b, c, e} = 4'b0111;
    #5;
    check("comb_d3", dc, 8'b0000_1000);
    {a, b, c, e} = 4'b0110;
    #5;
    check("comb_off", dc, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule : tb_demux_1to8

// File: doc/demux_1to8.md
Name: demux_1to8

Overview:
1-to-8 one-hot demultiplexer/decoder with enable. The 3-bit select {a,b,c} (a = MSB) steers the enable input e onto exactly one of eight outputs d0..d7; all other outputs are 0. It is used as a generic select/strobe fan-out block. Outputs are optionally registered in the single clock domain.

Parameters:
REGISTER_OUT, 1, 1 = outputs registered (one-cycle latency); 0 = outputs purely combinational from a,b,c,e (clk/rst_n unused).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
a  input  1  select bit 2 (MSB)
b  input  1  select bit 1
c  input  1  select bit 0 (LSB)
e  input  1  enable / data bit routed to the selected output
d0  output  1  high when e=1 and {a,b,c}=3'b000
d1  output  1  high when e=1 and {a,b,c}=3'b001
d2  output  1  high when e=1 and {a,b,c}=3'b010
d3  output  1  high when e=1 and {a,b,c}=3'b011
d4  output  1  high when e=1 and {a,b,c}=3'b100
d5  output  1  high when e=1 and {a,b,c}=3'b101
d6  output  1  high when e=1 and {a,b,c}=3'b110
d7  output  1  high when e=1 and {a,b,c}=3'b111

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Select index sel = {a,b,c}, unsigned 0..7.
- Next-output function: d[i] = e & (sel == i) for i = 0..7; {d7..d0} is one-hot when e=1, all-zero when e=0.
- Never more than one output high; no glitch-free guarantee in combinational mode.
- REGISTER_OUT=1:
  - All eight outputs are flops updated on rising clk edge with the next-output function of inputs sampled at that edge; latency exactly 1 cycle.
  - rst_n low: all outputs forced to 0 immediately (asynchronously), held 0 while rst_n low.
  - First rising edge after rst_n deasserts loads the current decode.
  - Reset asserted mid-operation: outputs clear at once regardless of clk; no state other than the output flops.
- REGISTER_OUT=0: outputs follow inputs combinationally with zero latency; rst_n and clk have no effect.
- X/Z on any select bit while e=1: outputs undefined (no X-propagation requirement); with e=0 outputs must be 0.
- No handshake, no backpressure; every cycle is independent.

Decomposition:
- Shared package demux_pkg: localparam NUM_OUT = 8, SEL_W = 3; typedef logic [SEL_W-1:0] sel_t; typedef logic [NUM_OUT-1:0] onehot_t.
- One sub-module natural: decoder_3to8 (combinational: sel_t sel, logic en -> onehot_t y). demux_1to8 wraps it, adds the optional output register stage (generate on REGISTER_OUT), and fans the bus out to d0..d7.

Test Plan:
- Reset: REGISTER_OUT=1, a=b=c=1, e=1, rst_n=0 -> d0..d7 = 00000000 asynchronously, before any clk edge; stays 0 until rst_n=1 plus one edge, then d7=1.
- Full sweep enabled: for sel 0..7 with e=1 -> after one clk edge exactly d[sel]=1 (e.g. a,b,c=0,1,0 -> d2=1, others 0; a,b,c=1,0,1 -> d5=1).
- Full sweep disabled: all 8 sel values with e=0 -> d0..d7 all 0 every cycle.
- Latency: change sel from 3'b000 to 3'b111 with e=1 at edge N -> d0=1 through edge N, d7=1 (d0=0) only after edge N+1; one-hot check every cycle.
- Mid-run reset: e=1, sel=3'b100 (d4=1), pulse rst_n low between edges -> d4 drops to 0 immediately; after release and next edge d4=1 again.
- Combinational variant: REGISTER_OUT=0, apply {a,b,c,e}=0,1,1,1, wait 5 ns -> d3=1 only; {a,b,c,e}=0,1,1,0 -> all 0, no clock toggled.
